gf8_mul_sched: RTL and testbench

- Scheduler that shares one combinational GF(2^8) multiplier among NREQ requesters.
- Two operations: single multiply (MUL) and multiplicative inverse (INV). INV is computed as a^254 by a sequenced square/multiply chain on the same multiplier.
- Round-robin arbitration; one operation in flight; single response channel with backpressure.
- Sits in front of the field-multiplier datapath so that multiple consumers time-share the one multiplier instance.

---
 rtl/gf8_pkg.sv | 30 +++
 rtl/gf8_mul.sv | 37 +++
 rtl/gf8_mul_sched.sv | 180 ++++++++++++++++++
 tb/tb_gf8_mul_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf8_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : gf8_pkg                                               |
// | Purpose  : Shared types and constants for the GF(2^8) multiplier |
// |            scheduler: op encodings, FSM states, inverse chain    |
// |            length and default reduction polynomial.              |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package gf8_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_INV = 1'b1;

  // Square/multiply pairs that take a to a^127; one final square gives a^254
  localparam int INV_PAIRS = 6;

  // AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [8:0] C_POLY_DEFAULT = 9'h11B;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL     = 3'd1,
    INV_SQ  = 3'd2,
    INV_MA  = 3'd3,
    INV_FIN = 3'd4,
    RESP    = 3'd5
  } state_t;

endpackage : gf8_pkg
`default_nettype wire

// File: rtl/gf8_mul.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : gf8_mul                                               |
// | Purpose  : Combinational GF(2^8) multiplier: 8x8 carry-less      |
// |            product followed by reduction modulo POLY.            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module gf8_mul
  import gf8_pkg::*;
#(
  parameter logic [8:0] POLY = C_POLY_DEFAULT
) (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] p
);

  logic [14:0] w_acc;

  // Carry-less multiply, then fold bits 14..8 back down with the polynomial
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        w_acc = w_acc ^ ({7'b0, x} << i);
      end
    end
    for (int i = 14; i >= 8; i--) begin
      if (w_acc[i]) begin
        w_acc = w_acc ^ ({6'b0, POLY} << (i - 8));
      end
    end
    p = w_acc[7:0];
  end

endmodule : gf8_mul
`default_nettype wire

// File: rtl/gf8_mul_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : gf8_mul_sched                                         |
// | Purpose  : Round-robin scheduler sharing one GF(2^8) multiplier  |
// |            among NREQ requesters. Supports MUL and INV (a^254    |
// |            via a square/multiply chain) with one op in flight    |
// |            and a single backpressured response channel.          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module gf8_mul_sched
  import gf8_pkg::*;
#(
  parameter int         NREQ = 4,
  parameter logic [8:0] POLY = C_POLY_DEFAULT,
  parameter int         ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [7:0]        rsp_data,
  output logic              busy
);

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [7:0]      r_r;
  logic [ID_W-1:0] r_id;
  logic [2:0]      r_cnt;
  logic            r_rsp_valid;

  logic            w_gnt_any;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_gnt_op;
  logic [7:0]      w_gnt_a;
  logic [7:0]      w_gnt_b;
  logic [ID_W:0]   w_idx;
  logic [7:0]      w_mx;
  logic [7:0]      w_my;
  logic [7:0]      w_prod;

  // Rotating priority search: scan offsets high to low so the smallest
  // offset from rr_ptr wins, then pick up the winner's operands
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NREQ)) begin
        w_idx = w_idx - (ID_W+1)'(NREQ);
      end
      if (req_valid[w_idx[ID_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx[ID_W-1:0];
      end
    end
    w_gnt_op = 1'b0;
    w_gnt_a  = '0;
    w_gnt_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == w_gnt_id) begin
        w_gnt_op = req_op[i];
        w_gnt_a  = req_a[8*i +: 8];
        w_gnt_b  = req_b[8*i +: 8];
      end
    end
  end

  // Accept is only ever offered from IDLE and never while in reset
  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == IDLE) && w_gnt_any) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  // Multiplier operand steering by state
  always_comb begin
    w_mx = r_r;
    w_my = r_r;
    case (r_state)
      MUL: begin
        w_mx = r_a;
        w_my = r_b;
      end
      INV_MA: begin
        w_mx = r_r;
        w_my = r_a;
      end
      default: begin
        w_mx = r_r;
        w_my = r_r;
      end
    endcase
  end

  gf8_mul #(
    .POLY (POLY)
  ) u_mul (
    .x (w_mx),
    .y (w_my),
    .p (w_prod)
  );

  // Scheduler FSM: grant, run the multiply or inverse chain, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_r         <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_a      <= w_gnt_a;
            r_b      <= w_gnt_b;
            r_r      <= w_gnt_a;
            r_id     <= w_gnt_id;
            r_cnt    <= '0;
            r_rr_ptr <= (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_state  <= (w_gnt_op == OP_INV) ? INV_SQ : MUL;
          end
        end
        MUL: begin
          r_r         <= w_prod;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        INV_SQ: begin
          r_r     <= w_prod;
          r_state <= INV_MA;
        end
        INV_MA: begin
          r_r   <= w_prod;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == 3'(INV_PAIRS - 1)) begin
            r_state <= INV_FIN;
          end else begin
            r_state <= INV_SQ;
          end
        end
        INV_FIN: begin
          r_r         <= w_prod;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_r;
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);

endmodule : gf8_mul_sched
`default_nettype wire

// File: tb/tb_gf8_mul_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_gf8_mul_sched                                      |
// | Purpose  : Scoreboard bench for gf8_mul_sched: directed MUL/INV, |
// |            round-robin, backpressure, mid-op reset and random.   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_gf8_mul_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_data;
  logic              busy;

  gf8_mul_sched #(
    .NREQ (NREQ),
    .POLY (9'h11B),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         grant_log[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         grant_cnt[NREQ];
  int         req_base[NREQ];
  logic [7:0] exp_data[NREQ];
  int         exp_lat[NREQ];
  int         n_grants = 0;
  int         n_rsps   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: shift-and-xtime multiply, brute-force inverse
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] xx = x;
    logic [7:0] yy = y;
    for (int i = 0; i < 8; i++) begin
      if (yy[0]) p = p ^ xx;
      xx = xx[7] ? ((xx << 1) ^ 8'h1B) : (xx << 1);
      yy = yy >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grants push expectations, response handshakes pop them
  int         grant_cyc = 0;
  int         lat_exp   = 0;
  bit         prev_valid = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data  = '0;
  logic [1:0] prev_id    = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      prev_valid = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_data", 32'(rsp_data), 32'(prev_data));
        chk("bp_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && !prev_valid) chk("latency", cyc - grant_cyc, lat_exp);
      if (busy) chk("ready_busy", 32'(req_ready), 32'd0);
      if (req_ready != '0) begin
        chk("ready_onehot", $countones(req_ready), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            chk("ready_valid", 32'(req_valid[i]), 32'd1);
            sb_q.push_back('{i, exp_data[i]});
            grant_log.push_back(i);
            grant_cyc = cyc;
            lat_exp   = exp_lat[i];
            grant_cnt[i]++;
            n_grants++;
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_rsps++;
        chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
      prev_valid = rsp_valid;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
    req_op[i]        = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    exp_data[i]      = exp;
    exp_lat[i]       = op ? 14 : 2;
    req_base[i]      = grant_cnt[i];
    req_valid[i]     = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (grant_cnt[i] == req_base[i] && n < 200) begin
      tick();
      n++;
    end
    chk("granted", 32'(grant_cnt[i] != req_base[i]), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || rsp_valid || sb_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("drain", 32'(busy || rsp_valid || (sb_q.size() != 0)), 32'd0);
  endtask

  function automatic int log_at(input int k);
    return (grant_log.size() > k) ? grant_log[k] : -1;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    int issued;
    int g0;
    int r0;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;

    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt[i] = 0;
      req_base[i]  = 0;
      exp_data[i]  = '0;
      exp_lat[i]   = 0;
    end

    // Reset state, and no accept while reset is high
    tick();
    tick();
    req_valid[1] = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    req_valid[1] = 1'b0;
    rst = 1'b0;
    tick();

    // Single MUL
    set_req(0, 1'b0, 8'h57, 8'h83, 8'hC1);
    wait_grant(0);
    wait_done();

    // INV cases including 0 and 1, and MUL by zero
    set_req(2, 1'b1, 8'h53, 8'h00, 8'hCA); wait_grant(2); wait_done();
    set_req(2, 1'b1, 8'h00, 8'h77, 8'h00); wait_grant(2); wait_done();
    set_req(2, 1'b1, 8'h01, 8'h00, 8'h01); wait_grant(2); wait_done();
    set_req(1, 1'b0, 8'h00, 8'h5A, 8'h00); wait_grant(1); wait_done();
    set_req(1, 1'b0, 8'h5A, 8'h00, 8'h00); wait_grant(1); wait_done();

    // Backpressure: hold RESP for 5 cycles with another request waiting
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 8'h02, 8'h87, 8'h15);
    wait_grant(1);
    set_req(3, 1'b0, 8'h03, 8'h03, 8'h05);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_reach_resp", 32'(rsp_valid), 32'd1);
    idx = grant_log.size();
    repeat (5) tick();
    chk("bp_no_grant", grant_log.size() - idx, 32'd0);
    rsp_ready = 1'b1;
    wait_grant(3);
    wait_done();

    // Reset mid-INV: operation abandoned, pointer back to requester 0
    set_req(2, 1'b1, 8'h53, 8'h00, 8'hCA);
    wait_grant(2);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    idx = grant_log.size();
    set_req(3, 1'b0, 8'h02, 8'h87, 8'h15);
    set_req(0, 1'b0, 8'h57, 8'h83, 8'hC1);
    wait_grant(0);
    wait_grant(3);
    wait_done();
    chk("midrst_first", log_at(idx), 32'd0);
    chk("midrst_second", log_at(idx + 1), 32'd3);

    // Round-robin with all requesters continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idx = grant_log.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h02, 8'h87, 8'h15);
    n = 0;
    while (grant_log.size() < idx + 5 && n < 200) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_done();
    for (int k = 0; k < 5; k++) chk("rr_order", log_at(idx + k), 32'(k % NREQ));

    // Random mixed traffic with random backpressure
    issued = 0;
    n      = 0;
    g0     = n_grants;
    r0     = n_rsps;
    while ((issued < 1000 || req_valid != '0 || busy || rsp_valid || sb_q.size() != 0)
           && n < 60000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && grant_cnt[i] != req_base[i]) req_valid[i] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && issued < 1000 && $urandom_range(0, 3) == 0) begin
          op = 1'($urandom_range(0, 1));
          a  = 8'($urandom);
          b  = 8'($urandom);
          set_req(i, op, a, b, op ? ginv(a) : gmul(a, b));
          issued++;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("rand_timeout", 32'(n < 60000), 32'd1);
    chk("rand_grants", n_grants - g0, 32'd1000);
    chk("rand_rsps", n_rsps - r0, 32'd1000);
    chk("rand_sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gf8_mul_sched
`default_nettype wire
